// File: rtl/screen_sequencer.sv
// Frame-synchronous START/GAME/OVER screen sequencer for the 96x64 OLED.
// Screen requests are latched as pending and committed only on frame_begin; also muxes pixel sources.
module screen_sequencer #(
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned END_HOLD_FRAMES = 120,
    parameter int unsigned PROMPT_START    = 2208,
    parameter logic [15:0] BG_COLOUR       = 16'h0044
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        mouse_left,
    input  logic        game_over,
    input  logic [15:0] start_pixel,
    input  logic [15:0] game_pixel,
    input  logic [15:0] end_pixel,
    output logic [15:0] oled_data,
    output logic [1:0]  screen,
    output logic        game_start
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PIX_W = 13;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_MIN   = CNT_W'(END_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [PIX_W-1:0] PROMPT_IDX = PIX_W'(PROMPT_START);

    typedef enum logic [1:0] {
        S_START   = 2'd0,
        S_GAME    = 2'd1,
        S_OVER    = 2'd2,
        S_ILLEGAL = 2'd3
    } screen_t;

    screen_t          r_screen;
    screen_t          r_pending;
    logic             r_mouse_prev;
    logic             r_blink_on;
    logic [CNT_W-1:0] r_blink_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [15:0]      r_oled_data;
    logic             r_game_start;

    logic w_click;
    logic w_idle;
    logic w_commit;
    logic w_prompt_hidden;

    assign w_click         = mouse_left & ~r_mouse_prev;
    // New events are only accepted while no request is waiting for a frame boundary
    assign w_idle          = (r_pending == r_screen);
    assign w_commit        = frame_begin & ~w_idle;
    assign w_prompt_hidden = ~r_blink_on & (pixel_index >= PROMPT_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_screen     <= S_START;
            r_pending    <= S_START;
            r_mouse_prev <= 1'b0;
            r_blink_on   <= 1'b1;
            r_blink_cnt  <= '0;
            r_hold_cnt   <= '0;
            r_oled_data  <= BG_COLOUR;
            r_game_start <= 1'b0;
        end else begin
            r_mouse_prev <= mouse_left;
            r_game_start <= 1'b0;

            if (w_commit) begin
                r_screen     <= r_pending;
                r_game_start <= (r_pending == S_GAME);
                r_blink_cnt  <= '0;
                r_hold_cnt   <= '0;
                r_blink_on   <= 1'b1;
            end else begin
                if (w_idle) begin
                    case (r_screen)
                        S_START: if (w_click) r_pending <= S_GAME;
                        S_GAME:  if (game_over) r_pending <= S_OVER;
                        S_OVER:  if (w_click && (r_hold_cnt >= HOLD_MIN)) r_pending <= S_START;
                        default: r_pending <= r_screen;
                    endcase
                end
                if (frame_begin) begin
                    if (r_screen == S_START) begin
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt <= '0;
                            r_blink_on  <= ~r_blink_on;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                        end
                    end
                    if ((r_screen == S_OVER) && (r_hold_cnt != CNT_MAX)) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
            end

            // Pixel mux follows the screen committed before this edge
            case (r_screen)
                S_START: r_oled_data <= w_prompt_hidden ? BG_COLOUR : start_pixel;
                S_GAME:  r_oled_data <= game_pixel;
                S_OVER:  r_oled_data <= end_pixel;
                default: r_oled_data <= BG_COLOUR;
            endcase
        end
    end

    assign oled_data  = r_oled_data;
    assign screen     = r_screen;
    assign game_start = r_game_start;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: a frame-counting reference model pushes expected
// outputs per cycle; a negedge monitor pops and compares them against the DUT.
module tb_screen_sequencer;

    localparam int unsigned BLINK    = 2;
    localparam int unsigned HOLD     = 3;
    localparam int unsigned PROMPT   = 2208;
    localparam logic [15:0] BG       = 16'h0044;

    typedef struct packed {
        logic [1:0]  scr;
        logic        gs;
        logic [15:0] pix;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic        mouse_left;
    logic        game_over;
    logic [15:0] start_pixel;
    logic [15:0] game_pixel;
    logic [15:0] end_pixel;
    logic [15:0] oled_data;
    logic [1:0]  screen;
    logic        game_start;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: committed screen, requested screen (-1 = none) and frames since last change
    int   m_screen = 0;
    int   m_req    = -1;
    int   m_frames = 0;
    bit   m_prev   = 1'b0;

    screen_sequencer #(
        .BLINK_FRAMES   (BLINK),
        .END_HOLD_FRAMES(HOLD),
        .PROMPT_START   (PROMPT),
        .BG_COLOUR      (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_begin(frame_begin),
        .pixel_index(pixel_index),
        .mouse_left (mouse_left),
        .game_over  (game_over),
        .start_pixel(start_pixel),
        .game_pixel (game_pixel),
        .end_pixel  (end_pixel),
        .oled_data  (oled_data),
        .screen     (screen),
        .game_start (game_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("screen",     16'(screen),     16'(e.scr));
            check("game_start", 16'(game_start), 16'(e.gs));
            check("oled_data",  oled_data,       e.pix);
        end
    end

    // Predict the outputs after the coming edge from the inputs now applied
    task automatic model_push();
        exp_t e;
        bit   click;
        bit   hidden;
        if (reset) begin
            m_screen = 0;
            m_req    = -1;
            m_frames = 0;
            m_prev   = 1'b0;
            e.scr    = 2'd0;
            e.gs     = 1'b0;
            e.pix    = BG;
        end else begin
            hidden = ((m_frames / BLINK) % 2 == 1) && (int'(pixel_index) >= PROMPT);
            case (m_screen)
                0:       e.pix = hidden ? BG : start_pixel;
                1:       e.pix = game_pixel;
                2:       e.pix = end_pixel;
                default: e.pix = BG;
            endcase
            click = mouse_left && !m_prev;
            e.gs  = 1'b0;
            if (frame_begin && m_req != -1) begin
                e.gs     = (m_req == 1);
                m_screen = m_req;
                m_req    = -1;
                m_frames = 0;
            end else begin
                if (m_req == -1) begin
                    if (m_screen == 0 && click) m_req = 1;
                    else if (m_screen == 1 && game_over) m_req = 2;
                    else if (m_screen == 2 && click && m_frames >= HOLD) m_req = 0;
                end
                if (frame_begin) m_frames++;
            end
            m_prev = mouse_left;
            e.scr  = 2'(m_screen);
        end
        q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic fb, input logic ml, input logic go, input int pidx);
        reset       = rst;
        frame_begin = fb;
        mouse_left  = ml;
        game_over   = go;
        pixel_index = (pidx < 0) ? 13'($urandom_range(0, 6143)) : 13'(pidx);
        start_pixel = 16'($urandom);
        game_pixel  = 16'($urandom);
        end_pixel   = 16'($urandom);
        model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ml, input logic go);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ml, go, -1);
    endtask

    task automatic frame(input logic ml, input logic go);
        step(1'b0, 1'b1, ml, go, -1);
    endtask

    initial begin
        reset       = 1'b1;
        frame_begin = 1'b0;
        mouse_left  = 1'b0;
        game_over   = 1'b0;
        pixel_index = '0;
        start_pixel = '0;
        game_pixel  = '0;
        end_pixel   = '0;

        // Reset, then the start screen passes start_pixel through
        step(1'b1, 1'b0, 1'b0, 1'b0, 100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 100);

        // Prompt blink: hidden after two frames, visible again after two more
        frame(1'b0, 1'b0); idle(3, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 6143);
        frame(1'b0, 1'b0); idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2208);

        // Click held several cycles, commit much later at a frame boundary
        idle(5, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        idle(30, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(6, 1'b0, 1'b0);

        // Game over held high, click ignored inside the hold window
        idle(10, 1'b0, 1'b1);
        frame(1'b0, 1'b1);
        idle(3, 1'b0, 1'b1);
        frame(1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        // Hold satisfied: click then frame returns to START without game_start
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Click coincident with frame_begin commits on the following frame
        step(1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(3, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Two clicks in one START frame give a single transition
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        frame(1'b1, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Pending OVER lost by a reset before the frame boundary
        idle(2, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Randomised traffic
        begin
            logic ml;
            logic go;
            ml = 1'b0;
            go = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0)  ml = ~ml;
                if ($urandom_range(0, 29) == 0) go = ~go;
                step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                     ml, go, -1);
            end
        end

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Frame-synchronous screen controller for the 96x64 OLED. Sequences the game between the start screen, the game screen and the game-over screen, driven by mouse clicks and the game's `game_over` flag. Blinks the start-screen prompt and muxes the three pixel sources onto `oled_data`. Sits between the per-screen pixel generators and the OLED driver; screen changes are applied only at frame boundaries, so no frame shows two screens.

## Interface
- `BLINK_FRAMES`, 30: frames per prompt blink half-period (1..255).
- `END_HOLD_FRAMES`, 120: frames the game-over screen ignores clicks (0..255).
- `PROMPT_START`, 2208: first pixel_index of the blinking prompt region (row 23 onward).
- `BG_COLOUR`, 16'h0044: colour substituted for hidden prompt pixels.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `frame_begin` in 1: one-cycle pulse from the OLED driver at the start of each frame.
- `pixel_index` in 13: current pixel, 0..6143.
- `mouse_left` in 1: left-button level, already synchronised to `clk`.
- `game_over` in 1: level from the game logic, high when the game has ended.
- `start_pixel` in 16: start-screen colour for `pixel_index`.
- `game_pixel` in 16: game-screen colour.
- `end_pixel` in 16: game-over-screen colour.
- `oled_data` out 16: registered pixel colour to the OLED driver.
- `screen` out 2: committed screen: 0 START, 1 GAME, 2 OVER.
- `game_start` out 1: one-cycle pulse when GAME is committed.

## Operation
- Reset values: `screen`=0, pending=START, `oled_data`=`BG_COLOUR`, `game_start`=0, blink_on=1, blink_cnt=0, hold_cnt=0, mouse_prev=0.
- Click means `mouse_left` & ~mouse_prev, with mouse_prev registered every cycle.
- The pending register holds the requested next screen. It is evaluated every cycle against the committed `screen`:
  - START: a click sets pending=GAME.
  - GAME: `game_over`=1 sets pending=OVER. Clicks are ignored.
  - OVER: a click sets pending=START only if hold_cnt ≥ `END_HOLD_FRAMES`. Earlier clicks are discarded, not queued.
- Commit: on a cycle with `frame_begin`=1, `screen` ← pending.
  - If that changes `screen` to GAME, `game_start`=1 for exactly that one cycle.
  - A commit clears blink_cnt and hold_cnt, and sets blink_on=1.
- Once pending differs from `screen`, further events are ignored until the commit. Only one transition happens per frame boundary.
- Blink (START only): on each `frame_begin`, blink_cnt increments. When it reaches `BLINK_FRAMES`-1, it wraps to 0 and blink_on toggles.
- Hold (OVER only): on each `frame_begin`, hold_cnt increments and saturates at 255.
- Counters are 8-bit. Outside their state they are held at 0.
- Pixel mux, registered each cycle:
  - START: `start_pixel`, or `BG_COLOUR` when blink_on=0 and `pixel_index` ≥ `PROMPT_START`.
  - GAME: `game_pixel`.
  - OVER: `end_pixel`.
  - Illegal code 3: `BG_COLOUR`.
- Reset mid-operation: returns to the reset values on the next edge. A pending request is lost and no `game_start` pulse is emitted.

## Timing
- `oled_data` latency is 1 cycle from `pixel_index` and the pixel inputs. The mux uses the committed `screen` from the same cycle.
- Event to pending: 1 cycle. Pending to `screen`: at the next `frame_begin` after pending is set.
- A click in the same cycle as `frame_begin` is committed at the following `frame_begin`, not the current one.
- `game_start` rises in the cycle after the committing `frame_begin` edge, together with `screen`=1.
- `game_over` held high for many cycles yields exactly one GAME→OVER transition.
- `mouse_left` held high yields exactly one click.

## Test plan
- Reset: assert `reset` for 2 cycles → `screen`=0, `oled_data`=16'h0044, `game_start`=0. Then with `start_pixel`=16'hF899 and `pixel_index`=100 → `oled_data`=16'hF899 one cycle later.
- Click and commit: click at cycle 10, `frame_begin` at cycle 50 → `screen` stays 0 through cycle 50, becomes 1 after it; `game_start` is a single-cycle pulse; `oled_data` follows `game_pixel`.
- Blink with `BLINK_FRAMES`=2: on START, after 2 `frame_begin` pulses, `pixel_index`=3000 → `oled_data`=`BG_COLOUR`; `pixel_index`=200 → `start_pixel`. After 2 more pulses, `pixel_index`=3000 → `start_pixel` again.
- Game over and hold with `END_HOLD_FRAMES`=3: `game_over`=1 held, then `frame_begin` → `screen`=2. A click after 1 frame is ignored. After 3 frames, a click then `frame_begin` → `screen`=0 with no `game_start` pulse.
- Simultaneous events: click in the same cycle as `frame_begin` → commit at the next `frame_begin`. Two clicks within one frame in START → only one transition and one `game_start` pulse.
- Reset mid-operation: pending=OVER set in GAME, `reset` pulse before `frame_begin` → `screen`=0, counters 0; a later `frame_begin` does not commit OVER.
